// File: rtl/nzcv_status_register.sv
// Architectural Z/N/C/V status register fed from the execute stage, with a
// saturating count of in-flight flag-setting instructions for decode.
module nzcv_status_register #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PENDING = 3,
  parameter int CNT_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  input  logic                  shifter_carry,
  input  logic [3:0]            op_code,
  input  logic                  s_bit,
  input  logic                  ex_valid,
  input  logic                  s_issue,
  input  logic                  stall,
  input  logic                  flush,
  output logic [3:0]            flags_out,
  output logic                  flags_ready,
  output logic [CNT_WIDTH-1:0]  pending_count,
  output logic                  err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_PENDING);

  // Flag bit positions on the bus
  localparam int Z_B = 0;
  localparam int N_B = 1;
  localparam int C_B = 2;
  localparam int V_B = 3;

  logic [3:0]           flags_q, flags_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic commit, issue, is_arith;

  assign commit = ex_valid & s_bit & ~stall & ~flush;
  assign issue  = s_issue & ~stall & ~flush;

  always_comb begin
    is_arith = 1'b0;
    unique case (op_code)
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010, 4'b1011: is_arith = 1'b1;
      default:                            is_arith = 1'b0;
    endcase
  end

  // Logical ops take C from the shifter and leave V alone
  always_comb begin
    flags_d = flags_q;
    if (commit) begin
      flags_d[Z_B] = (alu_result == '0);
      flags_d[N_B] = alu_result[DATA_WIDTH-1];
      flags_d[C_B] = is_arith ? alu_carry : shifter_carry;
      flags_d[V_B] = is_arith ? alu_overflow : flags_q[V_B];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (flush) begin
      cnt_d = '0;
    end else if (issue && !commit) begin
      if (cnt_q == CNT_MAX) err_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (commit && !issue) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign flags_out     = flags_q;
  assign pending_count = cnt_q;
  assign flags_ready   = (cnt_q == '0);
  assign err           = err_q;

endmodule

// File: doc/nzcv_status_register.md
Name: nzcv_status_register

Overview:
- Producer side of the 4-bit Z N C V flag bus read by the branch/condition logic.
- Derives Z, N, C and V from the execute-stage ALU/shifter outputs and holds them in an architectural status register.
- Tracks in-flight flag-setting instructions so decode knows when the held flags are final.
- Sits between the execute stage and the condition-test logic in the data path.

Parameters:
DATA_WIDTH, 32, ALU result width
MAX_PENDING, 3, max flag-setting instructions in flight between decode issue and execute commit
CNT_WIDTH, 2, pending counter width; must satisfy 2^CNT_WIDTH > MAX_PENDING

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
alu_result  input  DATA_WIDTH  execute-stage ALU result
alu_carry  input  1  ALU carry out (ARM convention: subtract carry = NOT borrow)
alu_overflow  input  1  ALU signed overflow
shifter_carry  input  1  barrel-shifter carry out
op_code  input  4  data-processing opcode of execute instruction
s_bit  input  1  execute instruction requests flag update
ex_valid  input  1  execute stage holds a valid instruction
s_issue  input  1  decode issues a flag-setting instruction this cycle
stall  input  1  pipeline stall; blocks commit and issue
flush  input  1  squash all in-flight instructions
flags_out  output  4  held flags: [0]=Z [1]=N [2]=C [3]=V
flags_ready  output  1  no flag-setting instruction in flight
pending_count  output  CNT_WIDTH  in-flight flag-setting instructions
err  output  1  sticky protocol error

Behaviour:
- Reset (rst_n low at a clk edge, overrides all other inputs): flags_out=4'b0000, pending_count=0, err=0. flags_ready=1.
- Reset mid-operation discards pending state completely. No partial update occurs in the reset cycle.
- commit = ex_valid & s_bit & !stall & !flush.
- issue = s_issue & !stall & !flush.
- Flag derivation, applied on a commit edge:
  - Z = (alu_result == 0).
  - N = alu_result[DATA_WIDTH-1].
- Opcode classes:
  - Arithmetic: 0010 SUB, 0011 RSB, 0100 ADD, 0101 ADC, 0110 SBC, 0111 RSC, 1010 CMP, 1011 CMN.
  - Logical: all other opcodes (AND EOR TST TEQ ORR MOV BIC MVN).
- C and V by class:
  - Arithmetic: C = alu_carry, V = alu_overflow.
  - Logical: C = shifter_carry, V keeps its held value.
- Latency: flags_out changes on the commit edge and is visible the following cycle. No combinational path from inputs to flags_out.
- No commit: flags_out holds. Also holds during stall and flush.
- Pending counter, one registered update per edge (flush has priority over issue and commit):
  - flush: count := 0. In-flight work is squashed and the held flags are unchanged.
  - issue and commit in the same cycle: count unchanged.
  - issue only: count+1. If count == MAX_PENDING, count stays and err := 1.
  - commit only: count-1. If count == 0, count stays 0 and err := 1.
- flags_ready = (pending_count == 0), decoded from the registered count. Decode must not evaluate a condition while flags_ready=0.
- err clears only on reset.
- Wrap-around: the counter never wraps. It saturates at 0 and at MAX_PENDING, raising err as above.

Test Plan:
- Reset: drive random inputs with rst_n=0 for 2 cycles -> flags_out=0000, pending_count=0, flags_ready=1, err=0.
- Commit ADD (op 0100): alu_result=0, alu_carry=1, alu_overflow=0, s_bit=1, ex_valid=1 -> next cycle flags_out=4'b0101 (Z=1, C=1).
- Commit MOV (op 1101) after held V=1: alu_result=32'h8000_0000, shifter_carry=0 -> flags_out=4'b1010 (N=1, V held 1, C=0, Z=0).
- Issue then commit: s_issue pulse -> pending_count=1, flags_ready=0. Two cycles later, commit CMP with result 5 -> count=0, flags_ready=1, flags_out Z=0.
- Simultaneous issue+commit at count=1 -> count stays 1. Then stall=1 with s_issue=1 and a valid commit -> count and flags unchanged.
- Errors and flush:
  - Commit at count=0 -> err=1, count=0.
  - Reset, then 4 issues with MAX_PENDING=3 -> count=3, err=1.
  - Then flush -> count=0, flags_ready=1, flags_out unchanged.
